// File: rtl/bellek_hakemi_if.sv
// Requester-side bus of the memory arbiter.
// One instance per master; the arbiter takes the slave view.
interface bellek_hakemi_if #(
   parameter int VERI_BIT  = 32,
   parameter int ADRES_BIT = 32
);
   logic                 istek;
   logic [ADRES_BIT-1:0] adres;
   logic                 yaz;
   logic [VERI_BIT-1:0]  yaz_veri;
   logic                 kabul;
   logic                 gecerli;
   logic [VERI_BIT-1:0]  oku_veri;

   modport master (
      output istek, adres, yaz, yaz_veri,
      input  kabul, gecerli, oku_veri
   );

   modport slave (
      input  istek, adres, yaz, yaz_veri,
      output kabul, gecerli, oku_veri
   );
endinterface

// File: rtl/bellek_hakemi.sv
// Round-robin two-master arbiter for the single-port main memory.
// Writes finish in the accept cycle; reads wait a fixed latency.
module bellek_hakemi #(
   parameter int VERI_BIT    = 32,
   parameter int ADRES_BIT   = 32,
   parameter int OKU_GECIKME = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   bellek_hakemi_if.slave       p0,
   bellek_hakemi_if.slave       p1,
   output logic                 mesgul,
   output logic [ADRES_BIT-1:0] bellek_adres,
   output logic                 bellek_yaz,
   output logic [VERI_BIT-1:0]  bellek_yaz_veri,
   input  logic [VERI_BIT-1:0]  bellek_oku_veri
);

   typedef enum logic {BOS, BEKLE} durum_t;

   localparam logic [3:0] SAYAC_BAS = 4'(OKU_GECIKME - 1);

   durum_t               durum_r;
   durum_t               durum_n;
   logic                 oncelik_r;
   logic                 sahip_r;
   logic [ADRES_BIT-1:0] adres_r;
   logic [3:0]           sayac_r;

   logic                 sec0;
   logic                 sec1;
   logic                 kabul_var;
   logic                 kazanan;
   logic                 yaz_sec;

   // A lone requester wins outright; a tie goes to the preferred port.
   assign sec0 = p0.istek & (~p1.istek | ~oncelik_r);
   assign sec1 = p1.istek & (~p0.istek | oncelik_r);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) durum_r <= BOS;
      else     durum_r <= durum_n;
   end

   // Next state, accept pulses and memory bus drive.
   always_comb begin
      durum_n         = durum_r;
      p0.kabul        = 1'b0;
      p1.kabul        = 1'b0;
      bellek_adres    = '0;
      bellek_yaz      = 1'b0;
      bellek_yaz_veri = '0;
      mesgul          = 1'b0;
      kabul_var       = 1'b0;
      kazanan         = 1'b0;
      yaz_sec         = 1'b0;
      if (!rst) begin
         unique case (durum_r)
            BOS: begin
               if (sec0 | sec1) begin
                  kabul_var    = 1'b1;
                  kazanan      = sec1;
                  p0.kabul     = sec0;
                  p1.kabul     = sec1;
                  bellek_adres = sec1 ? p1.adres : p0.adres;
                  yaz_sec      = sec1 ? p1.yaz : p0.yaz;
                  if (yaz_sec) begin
                     bellek_yaz      = 1'b1;
                     bellek_yaz_veri = sec1 ? p1.yaz_veri
                                            : p0.yaz_veri;
                  end else begin
                     durum_n = BEKLE;
                  end
               end
            end
            BEKLE: begin
               mesgul       = 1'b1;
               bellek_adres = adres_r;
               if (sayac_r == 4'd0) durum_n = BOS;
            end
         endcase
      end
   end

   // Priority rotation, read bookkeeping and read-data return.
   always_ff @(posedge clk) begin
      if (rst) begin
         oncelik_r   <= 1'b0;
         sahip_r     <= 1'b0;
         adres_r     <= '0;
         sayac_r     <= 4'd0;
         p0.gecerli  <= 1'b0;
         p1.gecerli  <= 1'b0;
         p0.oku_veri <= '0;
         p1.oku_veri <= '0;
      end else begin
         p0.gecerli <= 1'b0;
         p1.gecerli <= 1'b0;
         if (kabul_var) begin
            oncelik_r <= ~kazanan;
            if (!yaz_sec) begin
               sahip_r <= kazanan;
               adres_r <= bellek_adres;
               sayac_r <= SAYAC_BAS;
            end
         end
         if (durum_r == BEKLE) begin
            if (sayac_r == 4'd0) begin
               if (sahip_r) begin
                  p1.oku_veri <= bellek_oku_veri;
                  p1.gecerli  <= 1'b1;
               end else begin
                  p0.oku_veri <= bellek_oku_veri;
                  p0.gecerli  <= 1'b1;
               end
            end else begin
               sayac_r <= sayac_r - 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bellek_hakemi.sv
// Directed bench for bellek_hakemi with OKU_GECIKME = 2.
// Inputs change at negedge; outputs are sampled 1 ns later.
module tb_bellek_hakemi;

   logic        clk;
   logic        rst;
   logic        mesgul;
   logic [31:0] bellek_adres;
   logic        bellek_yaz;
   logic [31:0] bellek_yaz_veri;
   logic [31:0] bellek_oku_veri;

   int checks;
   int errors;

   bellek_hakemi_if #(.VERI_BIT(32), .ADRES_BIT(32)) b0 ();
   bellek_hakemi_if #(.VERI_BIT(32), .ADRES_BIT(32)) b1 ();

   bellek_hakemi #(
      .VERI_BIT(32),
      .ADRES_BIT(32),
      .OKU_GECIKME(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .p0(b0),
      .p1(b1),
      .mesgul(mesgul),
      .bellek_adres(bellek_adres),
      .bellek_yaz(bellek_yaz),
      .bellek_yaz_veri(bellek_yaz_veri),
      .bellek_oku_veri(bellek_oku_veri)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: one known word, everything else a fixed pattern.
   always_comb begin
      if (bellek_adres == 32'h8000_0000)
         bellek_oku_veri = 32'h0050_0093;
      else
         bellek_oku_veri = bellek_adres ^ 32'hA5A5_0000;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      b0.istek = 0; b0.adres = '0; b0.yaz = 0; b0.yaz_veri = '0;
      b1.istek = 0; b1.adres = '0; b1.yaz = 0; b1.yaz_veri = '0;
   endtask

   task automatic do_reset();
      tick();
      rst = 1;
      idle_inputs();
      tick();
      rst = 0;
   endtask

   task automatic test_reset();
      tick();
      rst = 1;
      b0.istek = 1; b0.adres = 32'h1234_5678; b0.yaz = 1;
      b0.yaz_veri = 32'hCAFE_0001;
      #1;
      checks++;
      if (b0.kabul !== 1'b0 || bellek_yaz !== 1'b0) begin
         errors++;
         $display("FAIL reset_kabul kabul0=%b yaz=%b want 0 0",
                  b0.kabul, bellek_yaz);
      end
      checks++;
      if (bellek_adres !== 32'h0 || bellek_yaz_veri !== 32'h0) begin
         errors++;
         $display("FAIL reset_bus adres=%h veri=%h want 0 0",
                  bellek_adres, bellek_yaz_veri);
      end
      tick();
      #1;
      checks++;
      if (b0.gecerli !== 1'b0 || b1.gecerli !== 1'b0 ||
          b0.oku_veri !== 32'h0 || b1.oku_veri !== 32'h0 ||
          mesgul !== 1'b0) begin
         errors++;
         $display("FAIL reset_regs g0=%b g1=%b d0=%h d1=%h m=%b want 0",
                  b0.gecerli, b1.gecerli, b0.oku_veri, b1.oku_veri, mesgul);
      end
      idle_inputs();
      rst = 0;
      tick();
      #1;
      checks++;
      if (b0.kabul !== 1'b0 || b1.kabul !== 1'b0 ||
          bellek_adres !== 32'h0 || bellek_yaz !== 1'b0) begin
         errors++;
         $display("FAIL idle_bus k0=%b k1=%b adres=%h yaz=%b want 0",
                  b0.kabul, b1.kabul, bellek_adres, bellek_yaz);
      end
   endtask

   task automatic test_single_read();
      tick();
      b0.istek = 1; b0.adres = 32'h8000_0000; b0.yaz = 0;
      #1;
      checks++;
      if (b0.kabul !== 1'b1 || bellek_adres !== 32'h8000_0000 ||
          bellek_yaz !== 1'b0 || mesgul !== 1'b0) begin
         errors++;
         $display("FAIL rd_accept k0=%b adres=%h yaz=%b m=%b want 1 80000000 0 0",
                  b0.kabul, bellek_adres, bellek_yaz, mesgul);
      end
      for (int i = 1; i <= 2; i++) begin
         tick();
         b0.istek = 0;
         #1;
         checks++;
         if (mesgul !== 1'b1 || b0.kabul !== 1'b0 || b0.gecerli !== 1'b0 ||
             bellek_adres !== 32'h8000_0000) begin
            errors++;
            $display("FAIL rd_wait%0d m=%b k0=%b g0=%b adres=%h want 1 0 0 80000000",
                     i, mesgul, b0.kabul, b0.gecerli, bellek_adres);
         end
      end
      tick();
      #1;
      checks++;
      if (b0.gecerli !== 1'b1 || b0.oku_veri !== 32'h0050_0093 ||
          mesgul !== 1'b0 || b1.gecerli !== 1'b0) begin
         errors++;
         $display("FAIL rd_valid g0=%b d0=%h m=%b g1=%b want 1 00500093 0 0",
                  b0.gecerli, b0.oku_veri, mesgul, b1.gecerli);
      end
      tick();
      #1;
      checks++;
      if (b0.gecerli !== 1'b0 || b0.oku_veri !== 32'h0050_0093) begin
         errors++;
         $display("FAIL rd_hold g0=%b d0=%h want 0 00500093",
                  b0.gecerli, b0.oku_veri);
      end
   endtask

   task automatic test_dual_read();
      do_reset();
      tick();
      b0.istek = 1; b0.adres = 32'h8000_0000; b0.yaz = 0;
      b1.istek = 1; b1.adres = 32'h8000_0100; b1.yaz = 0;
      #1;
      checks++;
      if (b0.kabul !== 1'b1 || b1.kabul !== 1'b0) begin
         errors++;
         $display("FAIL dual_first k0=%b k1=%b want 1 0",
                  b0.kabul, b1.kabul);
      end
      for (int i = 1; i <= 2; i++) begin
         tick();
         b0.istek = 0;
         #1;
         checks++;
         if (b1.kabul !== 1'b0 || mesgul !== 1'b1) begin
            errors++;
            $display("FAIL dual_stall%0d k1=%b m=%b want 0 1",
                     i, b1.kabul, mesgul);
         end
      end
      tick();
      #1;
      checks++;
      if (b0.gecerli !== 1'b1 || b1.kabul !== 1'b1 ||
          bellek_adres !== 32'h8000_0100 || b0.oku_veri !== 32'h0050_0093) begin
         errors++;
         $display("FAIL dual_overlap g0=%b k1=%b adres=%h d0=%h want 1 1 80000100 00500093",
                  b0.gecerli, b1.kabul, bellek_adres, b0.oku_veri);
      end
      for (int i = 1; i <= 2; i++) begin
         tick();
         b1.istek = 0;
         #1;
         checks++;
         if (b1.gecerli !== 1'b0 || mesgul !== 1'b1) begin
            errors++;
            $display("FAIL dual_wait%0d g1=%b m=%b want 0 1",
                     i, b1.gecerli, mesgul);
         end
      end
      tick();
      #1;
      checks++;
      if (b1.gecerli !== 1'b1 || b1.oku_veri !== 32'h25A5_0100 ||
          b0.gecerli !== 1'b0 || b0.oku_veri !== 32'h0050_0093) begin
         errors++;
         $display("FAIL dual_valid1 g1=%b d1=%h g0=%b d0=%h want 1 25a50100 0 00500093",
                  b1.gecerli, b1.oku_veri, b0.gecerli, b0.oku_veri);
      end
   endtask

   task automatic test_write_alternate();
      logic [31:0] exp_a;
      logic [31:0] exp_d;
      tick();
      b0.istek = 1; b0.adres = 32'h0000_0100; b0.yaz = 1;
      b0.yaz_veri = 32'h1111_1111;
      b1.istek = 1; b1.adres = 32'h0000_0200; b1.yaz = 1;
      b1.yaz_veri = 32'h2222_2222;
      for (int i = 0; i < 4; i++) begin
         if (i != 0) tick();
         #1;
         exp_a = (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
         exp_d = (i % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222;
         checks++;
         if (b0.kabul !== (i % 2 == 0) || b1.kabul !== (i % 2 == 1) ||
             bellek_yaz !== 1'b1 || bellek_adres !== exp_a ||
             bellek_yaz_veri !== exp_d) begin
            errors++;
            $display("FAIL wr_alt%0d k0=%b k1=%b yaz=%b adres=%h veri=%h want adres=%h veri=%h",
                     i, b0.kabul, b1.kabul, bellek_yaz, bellek_adres,
                     bellek_yaz_veri, exp_a, exp_d);
         end
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_write_during_read();
      b0.istek = 1; b0.adres = 32'h8000_0000; b0.yaz = 0;
      #1;
      checks++;
      if (b0.kabul !== 1'b1) begin
         errors++;
         $display("FAIL wdr_accept k0=%b want 1", b0.kabul);
      end
      for (int i = 1; i <= 2; i++) begin
         tick();
         b0.istek = 0;
         b1.istek = 1; b1.adres = 32'h8000_0004; b1.yaz = 1;
         b1.yaz_veri = 32'hDEAD_BEEF;
         #1;
         checks++;
         if (b1.kabul !== 1'b0 || bellek_yaz !== 1'b0 || mesgul !== 1'b1) begin
            errors++;
            $display("FAIL wdr_stall%0d k1=%b yaz=%b m=%b want 0 0 1",
                     i, b1.kabul, bellek_yaz, mesgul);
         end
      end
      tick();
      #1;
      checks++;
      if (b0.gecerli !== 1'b1 || b1.kabul !== 1'b1 || bellek_yaz !== 1'b1 ||
          bellek_adres !== 32'h8000_0004 || bellek_yaz_veri !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL wdr_write g0=%b k1=%b yaz=%b adres=%h veri=%h want 1 1 1 80000004 deadbeef",
                  b0.gecerli, b1.kabul, bellek_yaz, bellek_adres, bellek_yaz_veri);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_reset_mid_read();
      b0.istek = 1; b0.adres = 32'h8000_0000; b0.yaz = 0;
      #1;
      checks++;
      if (b0.kabul !== 1'b1) begin
         errors++;
         $display("FAIL rmr_accept k0=%b want 1", b0.kabul);
      end
      tick();
      b0.istek = 0;
      rst = 1;
      #1;
      checks++;
      if (bellek_adres !== 32'h0 || mesgul !== 1'b0 || b0.kabul !== 1'b0) begin
         errors++;
         $display("FAIL rmr_inrst adres=%h m=%b k0=%b want 0 0 0",
                  bellek_adres, mesgul, b0.kabul);
      end
      tick();
      rst = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (b0.gecerli !== 1'b0 || b0.oku_veri !== 32'h0 ||
             b1.oku_veri !== 32'h0 || mesgul !== 1'b0 ||
             bellek_adres !== 32'h0) begin
            errors++;
            $display("FAIL rmr_after%0d g0=%b d0=%h d1=%h m=%b adres=%h want all 0",
                     i, b0.gecerli, b0.oku_veri, b1.oku_veri, mesgul, bellek_adres);
         end
         tick();
      end
      b0.istek = 1; b0.adres = 32'h0000_0010; b0.yaz = 1;
      b0.yaz_veri = 32'h0000_00AA;
      b1.istek = 1; b1.adres = 32'h0000_0020; b1.yaz = 1;
      b1.yaz_veri = 32'h0000_00BB;
      #1;
      checks++;
      if (b0.kabul !== 1'b1 || b1.kabul !== 1'b0 ||
          bellek_adres !== 32'h0000_0010) begin
         errors++;
         $display("FAIL rmr_grant k0=%b k1=%b adres=%h want 1 0 00000010",
                  b0.kabul, b1.kabul, bellek_adres);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      logic [31:0] a;
      for (int i = 0; i < 5; i++) begin
         a = 32'h0000_1000 + 32'(i * 4);
         b0.istek = 1; b0.adres = a; b0.yaz = 1;
         b0.yaz_veri = 32'h5500_0000 + 32'(i);
         #1;
         checks++;
         if (b0.kabul !== 1'b1 || bellek_yaz !== 1'b1 ||
             bellek_adres !== a ||
             bellek_yaz_veri !== 32'h5500_0000 + 32'(i)) begin
            errors++;
            $display("FAIL b2b%0d k0=%b yaz=%b adres=%h veri=%h want adres=%h",
                     i, b0.kabul, bellek_yaz, bellek_adres, bellek_yaz_veri, a);
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1;
      idle_inputs();
      test_reset();
      test_single_read();
      test_dual_read();
      test_write_alternate();
      test_write_during_read();
      test_reset_mid_read();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
